// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the program-counter sequencer and the
// instruction ROM it addresses.
package pc_seq_pkg;

  // PC width: the ROM holds 2**A_DEFAULT words.
  localparam int A_DEFAULT  = 10;
  // Retired-instruction counter width.
  localparam int CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_if.sv
// Launch/ack handshake, decoded-instruction controls and ROM address bundle.
// The master side is the sequencer; the slave side is the launcher/decoder/ROM.
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int A  = A_DEFAULT,
  parameter int CW = CW_DEFAULT
) ();

  logic          start;
  logic [A-1:0]  start_addr;
  logic          stall;
  logic          branch_en;
  logic          branch_abs;
  logic [A-1:0]  branch_target;
  logic          halt_req;
  logic [A-1:0]  inst_address;
  logic          running;
  logic          ack;
  logic [CW-1:0] inst_count;

  modport master (
    input  start, start_addr, stall, branch_en, branch_abs, branch_target, halt_req,
    output inst_address, running, ack, inst_count
  );

  modport slave (
    output start, start_addr, stall, branch_en, branch_abs, branch_target, halt_req,
    input  inst_address, running, ack, inst_count
  );

endinterface : pc_seq_if

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: launches on a start rising edge, steps/branches
// the PC each cycle, halts into DONE and counts retired instructions.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int A  = A_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  pc_seq_if.master    bus
);

  seq_state_t    state;
  logic          start_q;
  logic [A-1:0]  pc_q;
  logic [CW-1:0] count_q;
  logic          launch;

  assign launch = bus.start & ~start_q;

  // NOTE: every register below is assigned with <= so all of them update
  // from the same pre-edge values; reset is synchronous and beats any input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            pc_q    <= bus.start_addr;
            count_q <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            // Saturate rather than wrap so long programs still report a bound.
            if (count_q != {CW{1'b1}}) count_q <= count_q + CW'(1);
            if (bus.halt_req) begin
              state <= DONE;
            end else if (bus.branch_en) begin
              pc_q <= bus.branch_abs ? bus.branch_target : pc_q + bus.branch_target;
            end else begin
              pc_q <= pc_q + A'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inst_address = pc_q;
  assign bus.inst_count   = count_q;
  assign bus.running      = (state == RUN);
  assign bus.ack          = (state == DONE);

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (A=10, CW=4 so saturation is reachable).
module tb_pc_sequencer;

  localparam int A  = 10;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  pc_seq_if #(.A(A), .CW(CW)) bus ();

  pc_sequencer #(.A(A), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input int addr, input int cnt,
                             input logic run, input logic ack);
    check({tag, ".addr"}, 32'(bus.inst_address), 32'(addr));
    check({tag, ".cnt"},  32'(bus.inst_count),   32'(cnt));
    check({tag, ".run"},  32'(bus.running),      32'(run));
    check({tag, ".ack"},  32'(bus.ack),          32'(ack));
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_abs = 1'b0;
    bus.branch_target = '0;
    bus.halt_req = 1'b0;

    // Reset state
    step();
    step();
    check_state("reset", 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_state("idle", 0, 0, 1'b0, 1'b0);

    // Straight line 5..9, halt at 9
    bus.start = 1'b1;
    bus.start_addr = 10'd5;
    step();
    check_state("launch5", 5, 0, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("seq.addr", 32'(bus.inst_address), 32'(5 + k));
    end
    bus.halt_req = 1'b1;
    step();
    check_state("halt9", 9, 5, 1'b0, 1'b1);
    bus.halt_req = 1'b0;
    step();
    check_state("done9", 9, 5, 1'b0, 1'b1);

    // Relative branch -4 from 20, absolute back to 20, absolute to 100
    bus.start = 1'b1;
    bus.start_addr = 10'd20;
    step();
    check_state("launch20", 20, 0, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.branch_en = 1'b1;
    bus.branch_abs = 1'b0;
    bus.branch_target = 10'h3FC;
    step();
    check_state("rel-4", 16, 1, 1'b1, 1'b0);
    bus.branch_abs = 1'b1;
    bus.branch_target = 10'd20;
    step();
    check_state("abs20", 20, 2, 1'b1, 1'b0);
    bus.branch_target = 10'd100;
    step();
    check_state("abs100", 100, 3, 1'b1, 1'b0);
    bus.branch_en = 1'b0;
    bus.branch_abs = 1'b0;
    bus.halt_req = 1'b1;
    step();
    check_state("halt100", 100, 4, 1'b0, 1'b1);
    bus.halt_req = 1'b0;

    // Wrap 1022 -> 1023 -> 0 -> 1 -> 2, then -3 wraps back to 1023
    bus.start = 1'b1;
    bus.start_addr = 10'd1022;
    step();
    check_state("launch1022", 1022, 0, 1'b1, 1'b0);
    bus.start = 1'b0;
    step();
    check("wrap.1023", 32'(bus.inst_address), 32'd1023);
    step();
    check("wrap.0", 32'(bus.inst_address), 32'd0);
    step();
    check("wrap.1", 32'(bus.inst_address), 32'd1);
    step();
    check_state("wrap.2", 2, 4, 1'b1, 1'b0);
    bus.branch_en = 1'b1;
    bus.branch_target = 10'h3FD;
    step();
    check_state("rel-3wrap", 1023, 5, 1'b1, 1'b0);
    bus.branch_en = 1'b0;
    bus.halt_req = 1'b1;
    step();
    check_state("halt1023", 1023, 6, 1'b0, 1'b1);
    bus.halt_req = 1'b0;

    // Stall outranks halt and branch
    bus.start = 1'b1;
    bus.start_addr = 10'd30;
    step();
    check_state("launch30", 30, 0, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.stall = 1'b1;
    bus.halt_req = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_abs = 1'b1;
    bus.branch_target = 10'd77;
    for (int k = 0; k < 3; k++) begin
      step();
      check_state("stall", 30, 0, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    check_state("halt30", 30, 1, 1'b0, 1'b1);
    bus.halt_req = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_abs = 1'b0;

    // Reset mid-program with start held high
    bus.start = 1'b1;
    bus.start_addr = 10'd38;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_state("pc40", 40, 2, 1'b1, 1'b0);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.start_addr = 10'd50;
    step();
    check_state("midreset", 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_state("relaunch50", 50, 0, 1'b1, 1'b0);
    step();
    check_state("held-start-run", 51, 1, 1'b1, 1'b0);
    bus.halt_req = 1'b1;
    step();
    check_state("halt51", 51, 2, 1'b0, 1'b1);
    bus.halt_req = 1'b0;

    // Start held high in DONE does not relaunch
    step();
    step();
    check_state("no-relaunch", 51, 2, 1'b0, 1'b1);
    bus.start = 1'b0;
    step();
    check_state("start-low", 51, 2, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.start_addr = 10'd200;
    step();
    check_state("launch200", 200, 0, 1'b1, 1'b0);
    bus.start = 1'b0;

    // Counter saturation at 15 over 20 straight-line instructions
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14 || k == 15 || k == 16 || k == 20)
        check_state("sat", 200 + k, (k > 15) ? 15 : k, 1'b1, 1'b0);
    end
    bus.halt_req = 1'b1;
    step();
    check_state("halt-sat", 220, 15, 1'b0, 1'b1);
    bus.halt_req = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_pc_sequencer
